// File: rtl/alu_issue_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage_pkg
// Purpose  : Shared constants for the ID->EX issue stage. This package holds
//            the RV32I opcode constants, the ALU FUNC_* function codes and
//            the operand-select encodings used by the decoder and the
//            operand muxes.
// Revision : 1.0 - initial release
// ============================================================================
package alu_issue_stage_pkg;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // ALU function codes
  localparam logic [3:0] FUNC_ADD = 4'd0;
  localparam logic [3:0] FUNC_SUB = 4'd1;
  localparam logic [3:0] FUNC_LLS = 4'd2;
  localparam logic [3:0] FUNC_XOR = 4'd3;
  localparam logic [3:0] FUNC_LRS = 4'd4;
  localparam logic [3:0] FUNC_ARS = 4'd5;
  localparam logic [3:0] FUNC_OR  = 4'd6;
  localparam logic [3:0] FUNC_AND = 4'd7;
  localparam logic [3:0] FUNC_BEQ = 4'd8;
  localparam logic [3:0] FUNC_BNE = 4'd9;
  localparam logic [3:0] FUNC_BLT = 4'd10;
  localparam logic [3:0] FUNC_BGE = 4'd11;

  // Operand 1 select
  localparam logic [1:0] SEL1_RS1  = 2'd0;
  localparam logic [1:0] SEL1_PC   = 2'd1;
  localparam logic [1:0] SEL1_ZERO = 2'd2;

  // Operand 2 select
  localparam logic [1:0] SEL2_RS2   = 2'd0;
  localparam logic [1:0] SEL2_IMM   = 2'd1;
  localparam logic [1:0] SEL2_SHAMT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_issue_stage_alu_control.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage_alu_control
// Purpose  : Combinational decode of opcode/funct3/funct7 into the ALU
//            function code, operand selects, source-usage flags and pipeline
//            control bits. Unsupported encodings raise illegal and suppress
//            every side-effecting control bit.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage_alu_control
  import alu_issue_stage_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       imm_10,
  output logic [3:0] alu_op,
  output logic [1:0] in1_sel,
  output logic [1:0] in2_sel,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       branch,
  output logic       jump,
  output logic       illegal
);

  // Decode the instruction class, then squash controls if it is illegal
  always_comb begin
    alu_op    = FUNC_ADD;
    in1_sel   = SEL1_RS1;
    in2_sel   = SEL2_RS2;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        reg_write = 1'b1;
        case (funct3)
          3'b000:  alu_op = funct7_5 ? FUNC_SUB : FUNC_ADD;
          3'b001:  alu_op = FUNC_LLS;
          3'b100:  alu_op = FUNC_XOR;
          3'b101:  alu_op = funct7_5 ? FUNC_ARS : FUNC_LRS;
          3'b110:  alu_op = FUNC_OR;
          3'b111:  alu_op = FUNC_AND;
          default: illegal = 1'b1;   // SLT / SLTU are not supported
        endcase
      end
      OPC_OP_IMM: begin
        uses_rs1  = 1'b1;
        reg_write = 1'b1;
        in2_sel   = SEL2_IMM;
        case (funct3)
          3'b000:  alu_op = FUNC_ADD;
          3'b001: begin
            alu_op  = FUNC_LLS;
            in2_sel = SEL2_SHAMT;
          end
          3'b100:  alu_op = FUNC_XOR;
          3'b101: begin
            alu_op  = imm_10 ? FUNC_ARS : FUNC_LRS;
            in2_sel = SEL2_SHAMT;
          end
          3'b110:  alu_op = FUNC_OR;
          3'b111:  alu_op = FUNC_AND;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        uses_rs1  = 1'b1;
        reg_write = 1'b1;
        mem_read  = 1'b1;
        in2_sel   = SEL2_IMM;
      end
      OPC_STORE: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        mem_write = 1'b1;
        in2_sel   = SEL2_IMM;
      end
      OPC_JALR: begin
        uses_rs1  = 1'b1;
        reg_write = 1'b1;
        jump      = 1'b1;
        in2_sel   = SEL2_IMM;
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        branch   = 1'b1;
        case (funct3)
          3'b000:  alu_op = FUNC_BEQ;
          3'b001:  alu_op = FUNC_BNE;
          3'b100:  alu_op = FUNC_BLT;
          3'b101:  alu_op = FUNC_BGE;
          default: illegal = 1'b1;   // unsigned compares are not supported
        endcase
      end
      OPC_LUI: begin
        reg_write = 1'b1;
        in1_sel   = SEL1_ZERO;
        in2_sel   = SEL2_IMM;
      end
      OPC_AUIPC: begin
        reg_write = 1'b1;
        in1_sel   = SEL1_PC;
        in2_sel   = SEL2_IMM;
      end
      OPC_JAL: begin
        reg_write = 1'b1;
        jump      = 1'b1;
        in1_sel   = SEL1_PC;
        in2_sel   = SEL2_IMM;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      alu_op    = FUNC_ADD;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : ID/EX pipeline register feeding the ALU. Decodes the ALU
//            function, sources operands, generates hazard stalls, and
//            handles bubble/flush/hold for the ID->EX boundary.
//            Optional feature macro: ALU_FORWARD_EN (operand forwarding from
//            EX/MEM and MEM/WB; without it, RAW hazards stall until the
//            producer has reached MEM/WB).
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [6:0]          id_opcode,
  input  logic [2:0]          id_funct3,
  input  logic [6:0]          id_funct7,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic [4:0]          id_rd,
  input  logic [XLEN-1:0]     id_rs1_data,
  input  logic [XLEN-1:0]     id_rs2_data,
  input  logic [XLEN-1:0]     id_imm,
  input  logic [XLEN-1:0]     id_pc,
  input  logic                flush,
  input  logic                ex_stall,
  input  logic                exmem_reg_write,
  input  logic [4:0]          exmem_rd,
  input  logic [XLEN-1:0]     exmem_result,
  input  logic                memwb_reg_write,
  input  logic [4:0]          memwb_rd,
  input  logic [XLEN-1:0]     memwb_data,
  output logic                ex_valid,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [XLEN-1:0]     ex_alu_in_1,
  output logic [XLEN-1:0]     ex_alu_in_2,
  output logic [XLEN-1:0]     ex_store_data,
  output logic [4:0]          ex_rd,
  output logic [XLEN-1:0]     ex_pc,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_branch,
  output logic                ex_jump,
  output logic                ex_illegal
);

  logic [3:0]          dec_alu_op;
  logic [1:0]          dec_in1_sel, dec_in2_sel;
  logic                dec_uses_rs1, dec_uses_rs2;
  logic                dec_reg_write, dec_mem_read, dec_mem_write;
  logic                dec_branch, dec_jump, dec_illegal;

  logic [XLEN-1:0]     rs1_val, rs2_val, op1, op2;
  logic                hazard, load, kill;

  logic                ex_valid_q, ex_valid_d;
  logic [ALU_OP_W-1:0] ex_alu_op_q, ex_alu_op_d;
  logic [XLEN-1:0]     ex_alu_in_1_q, ex_alu_in_1_d;
  logic [XLEN-1:0]     ex_alu_in_2_q, ex_alu_in_2_d;
  logic [XLEN-1:0]     ex_store_data_q, ex_store_data_d;
  logic [4:0]          ex_rd_q, ex_rd_d;
  logic [XLEN-1:0]     ex_pc_q, ex_pc_d;
  logic [5:0]          ex_ctl_q, ex_ctl_d;   // {reg_write, mem_read, mem_write, branch, jump, illegal}

  logic                unused_funct7;
  assign unused_funct7 = ^{id_funct7[6], id_funct7[4:0]};

  alu_issue_stage_alu_control u_alu_control (
    .opcode    (id_opcode),
    .funct3    (id_funct3),
    .funct7_5  (id_funct7[5]),
    .imm_10    (id_imm[10]),
    .alu_op    (dec_alu_op),
    .in1_sel   (dec_in1_sel),
    .in2_sel   (dec_in2_sel),
    .uses_rs1  (dec_uses_rs1),
    .uses_rs2  (dec_uses_rs2),
    .reg_write (dec_reg_write),
    .mem_read  (dec_mem_read),
    .mem_write (dec_mem_write),
    .branch    (dec_branch),
    .jump      (dec_jump),
    .illegal   (dec_illegal)
  );

`ifdef ALU_FORWARD_EN
  logic unused_uses_rs1;
  assign unused_uses_rs1 = dec_uses_rs1;

  // Source operands with EX/MEM-over-MEM/WB forwarding; only loads stall
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (id_rs1 != 5'd0) begin
      if (exmem_reg_write && (exmem_rd == id_rs1))      rs1_val = exmem_result;
      else if (memwb_reg_write && (memwb_rd == id_rs1)) rs1_val = memwb_data;
      else                                              rs1_val = id_rs1_data;
    end
    if (id_rs2 != 5'd0) begin
      if (exmem_reg_write && (exmem_rd == id_rs2))      rs2_val = exmem_result;
      else if (memwb_reg_write && (memwb_rd == id_rs2)) rs2_val = memwb_data;
      else                                              rs2_val = id_rs2_data;
    end
    hazard = ex_valid_q && ex_ctl_q[4] && (ex_rd_q != 5'd0) &&
             ((ex_rd_q == id_rs1) || (dec_uses_rs2 && (ex_rd_q == id_rs2)));
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_data};

  // Register-file operands; stall while a producer sits in ID/EX or EX/MEM
  always_comb begin
    rs1_val = (id_rs1 != 5'd0) ? id_rs1_data : '0;
    rs2_val = (id_rs2 != 5'd0) ? id_rs2_data : '0;
    hazard  = (dec_uses_rs1 && (id_rs1 != 5'd0) &&
               ((ex_valid_q && ex_ctl_q[5] && (ex_rd_q == id_rs1)) ||
                (exmem_reg_write && (exmem_rd == id_rs1)))) ||
              (dec_uses_rs2 && (id_rs2 != 5'd0) &&
               ((ex_valid_q && ex_ctl_q[5] && (ex_rd_q == id_rs2)) ||
                (exmem_reg_write && (exmem_rd == id_rs2))));
  end
`endif

  // Operand muxes
  always_comb begin
    case (dec_in1_sel)
      SEL1_PC:   op1 = id_pc;
      SEL1_ZERO: op1 = '0;
      default:   op1 = rs1_val;
    endcase
    case (dec_in2_sel)
      SEL2_IMM:   op2 = id_imm;
      SEL2_SHAMT: op2 = {{(XLEN-5){1'b0}}, id_imm[4:0]};
      default:    op2 = rs2_val;
    endcase
  end

  // A flushed instruction is consumed and dropped, so ready stays high
  assign id_ready = flush || (!ex_stall && !hazard);

  // Next ID/EX contents: flush > hold > hazard bubble > load > bubble
  always_comb begin
    load = 1'b0;
    kill = 1'b0;
    if (flush)          kill = 1'b1;
    else if (!ex_stall) begin
      if (!hazard && id_valid) load = 1'b1;
      else                     kill = 1'b1;
    end
    ex_valid_d      = ex_valid_q;
    ex_alu_op_d     = ex_alu_op_q;
    ex_alu_in_1_d   = ex_alu_in_1_q;
    ex_alu_in_2_d   = ex_alu_in_2_q;
    ex_store_data_d = ex_store_data_q;
    ex_rd_d         = ex_rd_q;
    ex_pc_d         = ex_pc_q;
    ex_ctl_d        = ex_ctl_q;
    if (load) begin
      ex_valid_d      = 1'b1;
      ex_alu_op_d     = ALU_OP_W'(dec_alu_op);
      ex_alu_in_1_d   = op1;
      ex_alu_in_2_d   = op2;
      ex_store_data_d = rs2_val;
      ex_rd_d         = id_rd;
      ex_pc_d         = id_pc;
      ex_ctl_d        = {dec_reg_write, dec_mem_read, dec_mem_write,
                         dec_branch, dec_jump, dec_illegal};
    end else if (kill) begin
      ex_valid_d = 1'b0;
      ex_ctl_d   = '0;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q      <= 1'b0;
      ex_alu_op_q     <= ALU_OP_W'(FUNC_ADD);
      ex_alu_in_1_q   <= '0;
      ex_alu_in_2_q   <= '0;
      ex_store_data_q <= '0;
      ex_rd_q         <= '0;
      ex_pc_q         <= '0;
      ex_ctl_q        <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_alu_op_q     <= ex_alu_op_d;
      ex_alu_in_1_q   <= ex_alu_in_1_d;
      ex_alu_in_2_q   <= ex_alu_in_2_d;
      ex_store_data_q <= ex_store_data_d;
      ex_rd_q         <= ex_rd_d;
      ex_pc_q         <= ex_pc_d;
      ex_ctl_q        <= ex_ctl_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_alu_op     = ex_alu_op_q;
  assign ex_alu_in_1   = ex_alu_in_1_q;
  assign ex_alu_in_2   = ex_alu_in_2_q;
  assign ex_store_data = ex_store_data_q;
  assign ex_rd         = ex_rd_q;
  assign ex_pc         = ex_pc_q;
  assign ex_reg_write  = ex_ctl_q[5];
  assign ex_mem_read   = ex_ctl_q[4];
  assign ex_mem_write  = ex_ctl_q[3];
  assign ex_branch     = ex_ctl_q[2];
  assign ex_jump       = ex_ctl_q[1];
  assign ex_illegal    = ex_ctl_q[0];

endmodule
`default_nettype wire
